// File: rtl/full_logic.sv
// ---------------------------------------------------------------------------
// full_logic -- write-side pointer and flag logic for an asynchronous FIFO.
//
// Keeps the binary write counter and its Gray-coded copy, and compares the
// next Gray pointer with the already-synchronised read pointer to register
// full / almost-full flags and the write-domain fill level.
//
// Parameters
//   a_width   address width, FIFO depth = 2**a_width (a_width >= 2)
//   af_level  almost-full threshold in entries (1 .. 2**a_width)
//
// Ports
//   Clk               in   write-domain clock, rising edge
//   Reset             in   asynchronous active-high reset
//   wr_en             in   write request
//   rd_syn_ptr        in   Gray read pointer, synchronised into Clk domain
//   wr_ptr            out  registered Gray write pointer
//   wr_addr           out  RAM write address (low bits of binary counter)
//   full_flag         out  registered full
//   almost_full_flag  out  registered fill level >= af_level
//   wr_level          out  registered fill level seen from write side
//   overflow_err      out  sticky write-while-full flag
//
// Configuration
//   FULL_LOGIC_OVF_EN  defined: overflow_err is a sticky register cleared
//                      only by Reset. Undefined: overflow_err is tied to 0.
// ---------------------------------------------------------------------------
module full_logic #(
  parameter int a_width  = 4,
  parameter int af_level = 12
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               wr_en,
  input  logic [a_width:0]   rd_syn_ptr,
  output logic [a_width:0]   wr_ptr,
  output logic [a_width-1:0] wr_addr,
  output logic               full_flag,
  output logic               almost_full_flag,
  output logic [a_width:0]   wr_level,
  output logic               overflow_err
);

  // Threshold sized to the level width so the compare is unsigned and exact.
  localparam logic [a_width:0] af_thr = af_level[a_width:0];

  logic [a_width:0] bin;
  logic [a_width:0] bin_next;
  logic [a_width:0] gray_next;
  logic [a_width:0] rd_bin;
  logic [a_width:0] level_next;
  logic [a_width:0] full_cmp;
  logic             accept;
  logic             full_val;
  logic             af_val;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [a_width:0] gray2bin(input logic [a_width:0] g);
    logic [a_width:0] b;
    b[a_width] = g[a_width];
    for (int i = a_width - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Next-state computation for counter, pointer, level and flags.
  always_comb begin
    accept     = wr_en & ~full_flag;
    bin_next   = bin + {{a_width{1'b0}}, accept};
    gray_next  = (bin_next >> 1) ^ bin_next;
    rd_bin     = gray2bin(rd_syn_ptr);
    level_next = bin_next - rd_bin;
    // Write pointer is full when it is one lap ahead of the read pointer:
    // in Gray code that means the top two bits inverted, the rest equal.
    full_cmp   = {~rd_syn_ptr[a_width:a_width-1], rd_syn_ptr[a_width-2:0]};
    full_val   = (gray_next == full_cmp);
    af_val     = (level_next >= af_thr);
  end

  // Counter, pointer, level and flag registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bin              <= '0;
      wr_ptr           <= '0;
      wr_level         <= '0;
      full_flag        <= 1'b0;
      almost_full_flag <= 1'b0;
    end else begin
      bin              <= bin_next;
      wr_ptr           <= gray_next;
      wr_level         <= level_next;
      full_flag        <= full_val;
      almost_full_flag <= af_val;
    end
  end

  assign wr_addr = bin[a_width-1:0];

`ifdef FULL_LOGIC_OVF_EN
  // Sticky overflow: any write attempt while full sets it until Reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      overflow_err <= 1'b0;
    end else if (wr_en && full_flag) begin
      overflow_err <= 1'b1;
    end else begin
      overflow_err <= overflow_err;
    end
  end
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_full_logic.sv
// ---------------------------------------------------------------------------
// tb_full_logic -- directed self-checking bench for full_logic
// (a_width=4, af_level=12). Expected overflow_err follows the
// FULL_LOGIC_OVF_EN build setting.
// ---------------------------------------------------------------------------
module tb_full_logic;

  logic       Clk;
  logic       Reset;
  logic       wr_en;
  logic [4:0] rd_syn_ptr;
  logic [4:0] wr_ptr;
  logic [3:0] wr_addr;
  logic       full_flag;
  logic       almost_full_flag;
  logic [4:0] wr_level;
  logic       overflow_err;

  int checks = 0;
  int errors = 0;

`ifdef FULL_LOGIC_OVF_EN
  localparam logic ovf_on = 1'b1;
`else
  localparam logic ovf_on = 1'b0;
`endif

  full_logic #(.a_width(4), .af_level(12)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .wr_en            (wr_en),
    .rd_syn_ptr       (rd_syn_ptr),
    .wr_ptr           (wr_ptr),
    .wr_addr          (wr_addr),
    .full_flag        (full_flag),
    .almost_full_flag (almost_full_flag),
    .wr_level         (wr_level),
    .overflow_err     (overflow_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wr_ptr"},   32'(wr_ptr),           32'd0);
    check({tag, ".wr_addr"},  32'(wr_addr),          32'd0);
    check({tag, ".full"},     32'(full_flag),        32'd0);
    check({tag, ".afull"},    32'(almost_full_flag), 32'd0);
    check({tag, ".level"},    32'(wr_level),         32'd0);
    check({tag, ".ovf"},      32'(overflow_err),     32'd0);
  endtask

  initial begin
    Reset      = 1'b1;
    wr_en      = 1'b0;
    rd_syn_ptr = 5'd0;

    // Reset with random inputs: outputs stay zero across edges.
    for (int i = 0; i < 3; i++) begin
      wr_en      = 1'($urandom_range(0, 1));
      rd_syn_ptr = 5'($urandom);
      step();
      check_all_zero($sformatf("rst_hold%0d", i));
    end
    wr_en      = 1'b0;
    rd_syn_ptr = 5'd0;
    Reset      = 1'b0;
    step();
    check_all_zero("rst_release");

    // Fill: 16 consecutive writes with read pointer at 0.
    wr_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("fill_addr%0d", k), 32'(wr_addr), 32'(k - 1));
      step();
      check($sformatf("fill_level%0d", k), 32'(wr_level), 32'(k));
      check($sformatf("fill_afull%0d", k), 32'(almost_full_flag), 32'(k >= 12));
      check($sformatf("fill_full%0d", k), 32'(full_flag), 32'(k == 16));
    end
    check("full_wr_ptr", 32'(wr_ptr), 32'h18);

    // Write attempts while full: nothing moves, overflow latches.
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("ovf_ptr%0d", i),   32'(wr_ptr),   32'h18);
      check($sformatf("ovf_level%0d", i), 32'(wr_level), 32'd16);
      check($sformatf("ovf_addr%0d", i),  32'(wr_addr),  32'd0);
      check($sformatf("ovf_full%0d", i),  32'(full_flag), 32'd1);
      check($sformatf("ovf_flag%0d", i),  32'(overflow_err), 32'(ovf_on));
    end
    wr_en = 1'b0;
    step();
    check("ovf_sticky", 32'(overflow_err), 32'(ovf_on));

    // One read becomes visible: full drops, level 15.
    rd_syn_ptr = 5'b00001;
    step();
    check("rd1_full",  32'(full_flag),        32'd0);
    check("rd1_level", 32'(wr_level),         32'd15);
    check("rd1_afull", 32'(almost_full_flag), 32'd1);
    check("rd1_ptr",   32'(wr_ptr),           32'h18);

    // One more write lands on the wrapped address 0 and refills.
    wr_en = 1'b1;
    check("wrap_addr_used", 32'(wr_addr), 32'd0);
    step();
    wr_en = 1'b0;
    check("wrap_ptr",   32'(wr_ptr),    32'h19);
    check("wrap_addr",  32'(wr_addr),   32'd1);
    check("wrap_full",  32'(full_flag), 32'd1);
    check("wrap_level", 32'(wr_level),  32'd16);
    check("wrap_ovf",   32'(overflow_err), 32'(ovf_on));

    // Asynchronous reset mid-cycle, then refill to level 7.
    #2;
    Reset = 1'b1;
    #1;
    check_all_zero("async_rst1");
    step();
    rd_syn_ptr = 5'd0;
    Reset      = 1'b0;
    wr_en      = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
    end
    wr_en = 1'b0;
    check("lvl7_level", 32'(wr_level), 32'd7);
    check("lvl7_addr",  32'(wr_addr),  32'd7);
    #2;
    Reset = 1'b1;
    #1;
    check_all_zero("async_rst2");
    step();
    Reset = 1'b0;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    check("post_rst_addr",  32'(wr_addr),  32'd1);
    check("post_rst_level", 32'(wr_level), 32'd1);
    check("post_rst_ptr",   32'(wr_ptr),   32'd1);
    check("post_rst_full",  32'(full_flag), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_logic.md
FULL_LOGIC -- requirements
Module: full_logic

Interface
REQ-001: Parameter a_width, default 4: address width; FIFO depth is 2**a_width; legal values are a_width >= 2.
REQ-002: Parameter af_level, default 12: almost-full threshold in entries; legal range is 1..2**a_width.
REQ-003: Clk  input  1  write-domain clock; all state updates on its rising edge.
REQ-004: Reset  input  1  asynchronous, active-high reset.
REQ-005: wr_en  input  1  write request from the write-side client.
REQ-006: rd_syn_ptr  input  a_width+1  Gray-coded read pointer, already synchronised into the Clk domain.
REQ-007: wr_ptr  output  a_width+1  registered Gray-coded write pointer, for synchronisation into the read domain.
REQ-008: wr_addr  output  a_width  RAM write address, equal to the low a_width bits of the binary write counter.
REQ-009: full_flag  output  1  registered full indication.
REQ-010: almost_full_flag  output  1  registered indication that the fill level is at or above af_level.
REQ-011: wr_level  output  a_width+1  registered fill level as seen from the write domain.
REQ-012: overflow_err  output  1  sticky flag for a write attempted while full.

Function
REQ-013: The binary write counter bin (a_width+1 bits) shall compute bin_next = bin + (wr_en & ~full_flag), wrapping modulo 2**(a_width+1).
REQ-014: The Gray next value shall be gray_next = (bin_next >> 1) ^ bin_next, and bin and wr_ptr shall load bin_next and gray_next on every Clk edge.
REQ-015: A write shall be accepted in a cycle only when wr_en=1 and full_flag=0, and that write shall use the current wr_addr.
REQ-016: Full detection shall be full_val = (gray_next == {~rd_syn_ptr[a_width:a_width-1], rd_syn_ptr[a_width-2:0]}), and full_flag shall register full_val every cycle.
REQ-017: The block shall convert rd_syn_ptr combinationally from Gray to binary as rd_bin, where rd_bin[i] is the XOR of rd_syn_ptr[a_width:i].
REQ-018: The block shall compute level_next = bin_next - rd_bin modulo 2**(a_width+1), and wr_level shall register level_next.
REQ-019: almost_full_flag shall register (level_next >= af_level).
REQ-020: All flags shall reflect the accepted write of the same cycle, with one cycle of latency from the Clk edge.
REQ-021: A write attempt while full_flag=1 shall leave bin, wr_ptr, wr_addr and wr_level unchanged.
REQ-022: A change in rd_syn_ptr shall be reflected in full_flag, wr_level and almost_full_flag at the next Clk edge.
REQ-023: Wrap-around: wr_addr shall roll from 2**a_width-1 to 0, and the counter MSB toggles on that roll.
REQ-024: full_flag and almost_full_flag shall be conservative; they may be stale high because of synchroniser delay, but they shall never be late low.

Reset
REQ-025: While Reset=1, asynchronously and independent of Clk: bin=0, wr_ptr=0, wr_addr=0, full_flag=0, almost_full_flag=0, wr_level=0, overflow_err=0.
REQ-026: Reset asserted mid-operation shall discard all state immediately, and the first Clk edge after Reset deasserts shall evaluate from the all-zero state.

Configuration
REQ-027: Macro FULL_LOGIC_OVF_EN defined: overflow_err shall be set on any Clk edge with wr_en=1 and full_flag=1, and shall be cleared only by Reset.
REQ-028: Macro FULL_LOGIC_OVF_EN undefined: overflow_err shall be tied to constant 0, no register shall be implemented for it, and all other behaviour shall be identical.

Verification (a_width=4, af_level=12, FULL_LOGIC_OVF_EN defined)
REQ-029: Reset pulse with random inputs -> all outputs 0 while Reset=1, and 0 on the first edge after release with wr_en=0.
REQ-030: rd_syn_ptr=0, 16 consecutive wr_en cycles -> wr_addr 0..15, and after the 16th edge full_flag=1, wr_ptr=5'b11000, wr_level=16.
REQ-031: Same sequence as REQ-030 -> almost_full_flag=1 first on the edge of the 12th accepted write (wr_level=12), and 0 before that.
REQ-032: FIFO full, wr_en held for 3 cycles -> wr_ptr stays 5'b11000, overflow_err=1 and remains 1 after wr_en drops, until Reset.
REQ-033: FIFO full, rd_syn_ptr=5'b00001 -> next edge full_flag=0, wr_level=15; one further write gives wr_addr wrapping to 0, bin=17, wr_ptr=5'b11001, full_flag=1.
REQ-034: Reset asserted mid-edge at wr_level=7 -> outputs go to 0 without a Clk edge; after release, a single write gives wr_addr=1, wr_level=1.
